object_layer_mixer: RTL

Parametrised successor to the single-rectangle hit tester. Holds NUM_OBJ rectangles with per-object colour and enable. Shadow registers are written at any time and committed to active registers only at vertical-blank start, so the display never tears. Hit-tests every object against the current VGA pixel in a 2-stage pipeline, resolves priority, and drives RGB. Also accumulates per-object collision flags each frame for game logic (ball/paddle/wall).

---
 rtl/object_layer_mixer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/object_layer_mixer.sv
// Multi-object rectangle layer: shadow/active object registers committed at
// vblank start, 2-stage per-pixel hit test with priority, colour output and collision flags.

module object_hit_lane #(
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic [XW-1:0] i_cx,
  input  logic [YW-1:0] i_cy,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  logic [XW-1:0] i_w,
  input  logic [YW-1:0] i_h,
  input  logic          i_vis,
  output logic          o_hit
);
  // One extra bit on the right edge so objects past the screen edge clip instead of wrapping.
  logic [XW:0] w_xe;
  logic [YW:0] w_ye;
  assign w_xe = {1'b0, i_x} + {1'b0, i_w};
  assign w_ye = {1'b0, i_y} + {1'b0, i_h};
  assign o_hit = i_vis & (i_cx >= i_x) & ({1'b0, i_cx} < w_xe)
                       & (i_cy >= i_y) & ({1'b0, i_cy} < w_ye);
endmodule

module object_layer_mixer #(
  parameter int NUM_OBJ = 4,
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int COLOR_W = 3,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XW-1:0]      CounterX,
  input  logic [YW-1:0]      CounterY,
  input  logic               inDisplayArea,
  input  logic               vblank,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [XW-1:0]      wr_x,
  input  logic [YW-1:0]      wr_y,
  input  logic [XW-1:0]      wr_w,
  input  logic [YW-1:0]      wr_h,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               wr_vis,
  output logic [COLOR_W-1:0] vga_rgb,
  output logic               pix_valid,
  output logic               any_hit,
  output logic [IDX_W-1:0]   hit_idx,
  output logic [NUM_OBJ-1:0] coll_status,
  output logic [7:0]         frame_cnt
);
  typedef struct packed {
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [XW-1:0]      w;
    logic [YW-1:0]      h;
    logic [COLOR_W-1:0] color;
    logic               vis;
  } obj_t;

  obj_t [NUM_OBJ-1:0] r_shadow, r_active;
  logic               r_pending, r_vblank_d;
  logic [7:0]         r_frame_cnt;
  logic [NUM_OBJ-1:0] r_hv, r_coll_acc, r_coll_status;
  logic               r_s1_de;
  logic [COLOR_W-1:0] r_rgb;
  logic               r_pv, r_any;
  logic [IDX_W-1:0]   r_idx;

  logic [NUM_OBJ-1:0] w_wr_sel, w_hv, w_coll_upd;
  logic               w_wr_ok, w_vb_rise, w_commit, w_multi, w_any;
  logic [IDX_W-1:0]   w_idx;

  // Out-of-range wr_idx selects no lane, so it neither writes nor sets pending.
  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_lane
    assign w_wr_sel[g] = wr_en & (wr_idx == IDX_W'(g));
    object_hit_lane #(.XW(XW), .YW(YW)) u_hit (
      .i_cx (CounterX),
      .i_cy (CounterY),
      .i_x  (r_active[g].x),
      .i_y  (r_active[g].y),
      .i_w  (r_active[g].w),
      .i_h  (r_active[g].h),
      .i_vis(r_active[g].vis),
      .o_hit(w_hv[g])
    );
  end

  assign w_wr_ok   = |w_wr_sel;
  assign w_vb_rise = vblank & ~r_vblank_d;
  assign w_commit  = w_vb_rise & r_pending;
  assign w_any     = |r_hv;
  assign w_multi   = |(r_hv & (r_hv - NUM_OBJ'(1)));
  assign w_coll_upd = (r_s1_de && w_multi) ? r_hv : '0;

  always_comb begin
    w_idx = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--)
      if (r_hv[i]) w_idx = IDX_W'(i);
  end

  // Commit reads the pre-write shadow; a coincident write stays pending for next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow    <= '0;
      r_active    <= '0;
      r_pending   <= 1'b0;
      r_vblank_d  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_vblank_d <= vblank;
      if (w_commit) begin
        r_active    <= r_shadow;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      for (int i = 0; i < NUM_OBJ; i++)
        if (w_wr_sel[i]) r_shadow[i] <= {wr_x, wr_y, wr_w, wr_h, wr_color, wr_vis};
      if (w_wr_ok)       r_pending <= 1'b1;
      else if (w_commit) r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hv          <= '0;
      r_s1_de       <= 1'b0;
      r_rgb         <= '0;
      r_pv          <= 1'b0;
      r_any         <= 1'b0;
      r_idx         <= '0;
      r_coll_acc    <= '0;
      r_coll_status <= '0;
    end else begin
      r_hv    <= w_hv;
      r_s1_de <= inDisplayArea;
      r_pv    <= r_s1_de;
      r_any   <= r_s1_de & w_any;
      r_idx   <= r_s1_de ? w_idx : '0;
      r_rgb   <= (r_s1_de & w_any) ? r_active[w_idx].color : '0;
      if (w_vb_rise) begin
        r_coll_status <= r_coll_acc | w_coll_upd;
        r_coll_acc    <= '0;
      end else begin
        r_coll_acc <= r_coll_acc | w_coll_upd;
      end
    end
  end

  assign vga_rgb     = r_rgb;
  assign pix_valid   = r_pv;
  assign any_hit     = r_any;
  assign hit_idx     = r_idx;
  assign coll_status = r_coll_status;
  assign frame_cnt   = r_frame_cnt;
endmodule
